// File: rtl/fifo_port_arbiter_if.sv
// Bundle between the shared-FIFO arbiter, its producers/consumers, the FIFO and the sequencer.
// The arbiter takes the slave side; the bench or surrounding system takes the master side.
interface fifo_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 5
);
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            wr_gnt;
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic                          rd_valid;
  logic [ID_WIDTH-1:0]           rd_id;
  logic [DATA_WIDTH-1:0]         rd_data;
  logic                          fifo_write;
  logic                          fifo_read;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [DATA_WIDTH-1:0]         fifo_data_out;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_overflow;
  logic                          fifo_underflow;
  logic                          hold;
  logic [CNT_WIDTH-1:0]          occ;
  logic                          busy;
  logic                          err;

  modport slave (
    input  wr_req, wr_data, rd_req, fifo_data_out, fifo_full, fifo_empty,
           fifo_overflow, fifo_underflow, hold,
    output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, fifo_write, fifo_read,
           fifo_data_in, occ, busy, err
  );

  modport master (
    output wr_req, wr_data, rd_req, fifo_data_out, fifo_full, fifo_empty,
           fifo_overflow, fifo_underflow, hold,
    input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, fifo_write, fifo_read,
           fifo_data_in, occ, busy, err
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Round-robin write/read arbiter sharing one FIFO: grants are combinational, read data returns 1 cycle after rd_gnt.
// Requesters simply stay un-granted while full/empty, held, or in the sticky error state.
module fifo_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_port_arbiter_if.slave   bus
);
  localparam int IW1 = ID_WIDTH + 1;

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_ERR} state_t;

  state_t                 r_state;
  logic                   r_err;
  logic [ID_WIDTH-1:0]    r_wr_ptr;
  logic [ID_WIDTH-1:0]    r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_occ;
  logic                   r_rd_valid;
  logic [ID_WIDTH-1:0]    r_rd_id;

  logic                   w_grant_ok;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic [ID_WIDTH:0]      w_wr_pick;
  logic [ID_WIDTH:0]      w_rd_pick;
  logic                   w_wr_go;
  logic                   w_rd_go;
  logic [ID_WIDTH-1:0]    w_wr_idx;
  logic [ID_WIDTH-1:0]    w_rd_idx;
  logic [NUM_REQ-1:0]     w_wr_gnt;
  logic [NUM_REQ-1:0]     w_rd_gnt;

  function automatic logic [ID_WIDTH-1:0] f_wrap(input logic [ID_WIDTH:0] s);
    logic [ID_WIDTH:0] t;
    t = s;
    if (t >= IW1'(NUM_REQ)) t = t - IW1'(NUM_REQ);
    return t[ID_WIDTH-1:0];
  endfunction

  // Returns {found, index}; scanning downward lets the lowest offset from ptr win.
  function automatic logic [ID_WIDTH:0] f_rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0]   res;
    logic [ID_WIDTH-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = f_wrap({1'b0, ptr} + IW1'(k));
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_grant_ok = (r_state == S_RUN) && !bus.hold;
  // Eligibility uses only the registered count, so same-cycle write/read never unblock each other.
  assign w_wr_ok    = w_grant_ok && (r_occ < CNT_WIDTH'(DEPTH)) && !bus.fifo_full;
  assign w_rd_ok    = w_grant_ok && (r_occ != '0) && !bus.fifo_empty;

  assign w_wr_pick  = f_rr_pick(bus.wr_req, r_wr_ptr);
  assign w_rd_pick  = f_rr_pick(bus.rd_req, r_rd_ptr);
  assign w_wr_go    = w_wr_ok && w_wr_pick[ID_WIDTH];
  assign w_rd_go    = w_rd_ok && w_rd_pick[ID_WIDTH];
  assign w_wr_idx   = w_wr_pick[ID_WIDTH-1:0];
  assign w_rd_idx   = w_rd_pick[ID_WIDTH-1:0];

  always_comb begin
    w_wr_gnt = '0;
    w_rd_gnt = '0;
    if (w_wr_go) w_wr_gnt[w_wr_idx] = 1'b1;
    if (w_rd_go) w_rd_gnt[w_rd_idx] = 1'b1;
  end

  assign bus.wr_gnt       = w_wr_gnt;
  assign bus.rd_gnt       = w_rd_gnt;
  assign bus.fifo_write   = w_wr_go;
  assign bus.fifo_read    = w_rd_go;
  assign bus.fifo_data_in = w_wr_go ? bus.wr_data[w_wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_id        = r_rd_id;
  assign bus.rd_data      = bus.fifo_data_out;
  assign bus.occ          = r_occ;
  assign bus.busy         = (r_occ != '0) || r_rd_valid;
  assign bus.err          = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_err   <= 1'b0;
    end else if (bus.fifo_overflow || bus.fifo_underflow) begin
      r_state <= S_ERR;
      r_err   <= 1'b1;
    end else begin
      case (r_state)
        S_RUN:   if (bus.hold)  r_state <= S_HOLD;
        S_HOLD:  if (!bus.hold) r_state <= S_RUN;
        default: r_state <= S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      if (w_wr_go) r_wr_ptr <= f_wrap({1'b0, w_wr_idx} + IW1'(1));
      if (w_rd_go) r_rd_ptr <= f_wrap({1'b0, w_rd_idx} + IW1'(1));
      case ({w_wr_go, w_rd_go})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      r_rd_valid <= w_rd_go;
      if (w_rd_go) r_rd_id <= w_rd_idx;
    end
  end
endmodule
